serial_frame_controller: RTL and testbench
==========================================

# serial_frame_controller

Sequencer for the serial input collector. Watches the serial line for a start bit and drives the collector's active-low shift enable (`ready`) for exactly OUTPUT_WIDTH cycles. It then checks the stop bit and latches the collector's parallel word into a holding register that downstream logic drains through a valid/accept handshake. It sits between the off-chip serial pin and the parallel datapath, alongside the collector instance.

## Interface
- OUTPUT_WIDTH, 16, data bits per frame; must match the collector; ≥2
- fast_clk  input  1  sole clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- serial_in  input  1  serial line: idle high, LSB first
- coll_data  input  OUTPUT_WIDTH  parallel word from the collector
- ready  output  1  collector shift enable; the collector shifts on edges where ready=0
- out_data  output  OUTPUT_WIDTH  latched word
- out_valid  output  1  out_data holds an unconsumed word
- out_accept  input  1  downstream takes the word on an edge where out_valid=1 and out_accept=1
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: good frame dropped because the holding register was full
- busy  output  1  high in any state other than IDLE

## Operation
- States:
  - IDLE: if serial_in=0 → SHIFT.
  - SHIFT: count cycles; on the edge where count=OUTPUT_WIDTH-1 → STOP.
  - STOP: sample the stop bit.
    - serial_in=1 → IDLE.
    - serial_in=0 → WAIT_HIGH.
  - WAIT_HIGH: stay until serial_in=1, then → IDLE.
- ready is registered.
  - 0 exactly while the state is SHIFT.
  - 1 in all other states.
- Bit counter is $clog2(OUTPUT_WIDTH) bits wide.
  - Cleared on entry to SHIFT.
  - Increments once per SHIFT cycle.
  - Never wraps in use.
- STOP with serial_in=1 (good frame):
  - If out_valid=0, or out_accept=1 on the same edge: out_data ← coll_data, out_valid stays/goes 1. The simultaneous accept+capture case loses no word.
  - Otherwise: out_data is unchanged, the new word is discarded, and overrun pulses.
- STOP with serial_in=0: frame_err pulses, out_data/out_valid are untouched, and the word is discarded.
- Accept without capture: out_valid → 0 on that edge. out_data holds its last value.
- out_accept while out_valid=0 is ignored.
- Reset asserted at any time, including mid-frame: immediately return to IDLE with all outputs at reset values. A partially shifted frame is lost; the collector contents are don't-care.

## Timing
- Reset values: ready=1, out_data=0, out_valid=0, frame_err=0, overrun=0, busy=0, state=IDLE, counter=0.
- Let E0 be the edge at which IDLE samples serial_in=0 (start bit).
- ready=0 from just after E0 until just after E(OUTPUT_WIDTH).
- The collector captures data bit i at edge E(i+1), for i=0..OUTPUT_WIDTH-1.
- Stop bit is sampled at E(OUTPUT_WIDTH+1).
- out_valid, frame_err and overrun update at E(OUTPUT_WIDTH+1).
- Latency from start-bit sample to out_valid: OUTPUT_WIDTH+1 edges.
- Frame period is OUTPUT_WIDTH+2 cycles. Back-to-back frames are supported: the next start bit may be sampled at E(OUTPUT_WIDTH+2).
- frame_err and overrun are high for exactly one cycle per event.
- serial_in is already synchronous to fast_clk; no synchronizer inside this block.

## Structure
- Shared package serial_pkg:
  - state enum {IDLE, SHIFT, STOP, WAIT_HIGH}
  - localparam for counter width
  - idle-line level constant (1'b1)
- One natural sub-module: frame_bit_counter (clear, enable, terminal-count output at OUTPUT_WIDTH-1).
- The holding register and handshake stay in the top module.
- The collector is instantiated beside this block at the next level up, not inside it.

## Test plan
- Single frame, OUTPUT_WIDTH=16, word 0xA5C3 LSB first with stop=1:
  - ready low for exactly 16 cycles.
  - out_valid rises at E17 with out_data=0xA5C3.
  - frame_err=0 and overrun=0.
- Two back-to-back frames 0x1234 then 0xFFFF, out_accept held 1:
  - both words appear in order.
  - no idle cycle is needed between frames.
  - out_valid stays high across the simultaneous accept+capture edge.
- Frame 0x00FF with stop bit 0, line then held low 5 cycles:
  - frame_err pulses once.
  - out_valid stays 0.
  - no new frame starts until the line returns high.
- Frame 0x1111 left unaccepted, then frame 0x2222:
  - overrun pulses at the second stop bit.
  - out_data stays 0x1111.
- Reset pulled low at data bit 7 of a frame:
  - ready=1, busy=0 and out_valid=0 immediately.
  - a following clean frame 0xBEEF is received correctly.
- out_accept pulsed while out_valid=0: no state change.

Source files
------------

// File: rtl/serial_frame_controller_pkg.sv
// Shared types and constants for the serial frame sequencer and its bit counter.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT     = 2'd1,
        STOP      = 2'd2,
        WAIT_HIGH = 2'd3
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam int   DEFAULT_OUTPUT_WIDTH = 16;

    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_OUTPUT_WIDTH);

endpackage

// File: rtl/serial_frame_controller_if.sv
// Downstream word handshake: a word transfers on a rising edge where out_valid and
// out_accept are both high; out_data is stable while out_valid=1 and not accepted.
interface serial_frame_controller_if #(
    parameter int OUTPUT_WIDTH = 16
) ();
    logic [OUTPUT_WIDTH-1:0] out_data;
    logic                    out_valid;
    logic                    out_accept;

    modport master (
        output out_data,
        output out_valid,
        input  out_accept
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_accept
    );
endinterface

// File: rtl/serial_frame_controller_counter.sv
// Data-bit counter for one frame: cleared at the start bit, counts SHIFT cycles.
module frame_bit_counter
    import serial_pkg::*;
#(
    parameter int OUTPUT_WIDTH = DEFAULT_OUTPUT_WIDTH
) (
    input  logic fast_clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);
    localparam int CW = cnt_width(OUTPUT_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(OUTPUT_WIDTH - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Holds at the terminal count so a power-of-two width never wraps to zero.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !tc_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge fast_clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == LAST);

endmodule

// File: rtl/serial_frame_controller.sv
// Sequences the serial collector through start, data and stop bits, then holds the
// collected word for a downstream valid/accept consumer.
module serial_frame_controller
    import serial_pkg::*;
#(
    parameter int OUTPUT_WIDTH = DEFAULT_OUTPUT_WIDTH
) (
    input  logic                    fast_clk,
    input  logic                    reset,
    input  logic                    serial_in,
    input  logic [OUTPUT_WIDTH-1:0] coll_data,
    output logic                    ready,
    output logic                    frame_err,
    output logic                    overrun,
    output logic                    busy,
    output state_t                  state_dbg,
    serial_frame_controller_if.master out_if
);
    state_t state_q, state_d;

    logic                    ready_q, ready_d;
    logic [OUTPUT_WIDTH-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    frame_err_q, frame_err_d;
    logic                    overrun_q, overrun_d;

    logic cnt_clear;
    logic cnt_enable;
    logic cnt_tc;

    frame_bit_counter #(
        .OUTPUT_WIDTH(OUTPUT_WIDTH)
    ) u_counter (
        .fast_clk (fast_clk),
        .reset    (reset),
        .clear_i  (cnt_clear),
        .enable_i (cnt_enable),
        .tc_o     (cnt_tc)
    );

    always_comb begin
        state_d    = state_q;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        case (state_q)
            IDLE: begin
                if (serial_in != LINE_IDLE) begin
                    state_d   = SHIFT;
                    cnt_clear = 1'b1;
                end
            end
            SHIFT: begin
                cnt_enable = 1'b1;
                if (cnt_tc) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                state_d = (serial_in == LINE_IDLE) ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (serial_in == LINE_IDLE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Accept and capture on the same edge keeps valid high with the new word.
    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        ready_d     = (state_d != SHIFT);

        if (valid_q && out_if.out_accept) begin
            valid_d = 1'b0;
        end

        if (state_q == STOP) begin
            if (serial_in == LINE_IDLE) begin
                if (!valid_q || out_if.out_accept) begin
                    data_d  = coll_data;
                    valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end else begin
                frame_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge fast_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign ready            = ready_q;
    assign frame_err        = frame_err_q;
    assign overrun          = overrun_q;
    assign busy             = (state_q != IDLE);
    assign state_dbg        = state_q;
    assign out_if.out_data  = data_q;
    assign out_if.out_valid = valid_q;

endmodule

// File: tb/tb_serial_frame_controller.sv
// Directed bench for serial_frame_controller: table of back-to-back frames plus
// hand-written sequences for accept-only, framing error and mid-frame reset.
module tb_serial_frame_controller;
    import serial_pkg::*;

    localparam int W = 16;

    logic         fast_clk = 1'b0;
    logic         reset;
    logic         serial_in;
    logic [W-1:0] coll_data = '0;
    logic         ready;
    logic         frame_err;
    logic         overrun;
    logic         busy;
    state_t       state_dbg;

    serial_frame_controller_if #(.OUTPUT_WIDTH(W)) out_if ();

    serial_frame_controller #(
        .OUTPUT_WIDTH(W)
    ) dut (
        .fast_clk  (fast_clk),
        .reset     (reset),
        .serial_in (serial_in),
        .coll_data (coll_data),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy),
        .state_dbg (state_dbg),
        .out_if    (out_if)
    );

    // Clock and the collector model (shifts LSB-first while ready is low).
    always #5 fast_clk = ~fast_clk;

    always @(posedge fast_clk) begin
        if (!ready) begin
            coll_data <= {serial_in, coll_data[W-1:1]};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int tests  = 0;
    int failed = 0;
    int ready_low_cnt;
    logic valid_before_stop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the stop-bit edge.
    task automatic send_frame(input logic [W-1:0] word, input logic stop, input logic acc);
        serial_in = 1'b0;
        out_if.out_accept = 1'b0;
        ready_low_cnt = 0;
        @(posedge fast_clk);
        for (int i = 0; i < W; i++) begin
            @(negedge fast_clk);
            if (!ready) ready_low_cnt++;
            serial_in = word[i];
        end
        @(posedge fast_clk);
        @(negedge fast_clk);
        if (!ready) ready_low_cnt++;
        valid_before_stop = out_if.out_valid;
        serial_in = stop;
        out_if.out_accept = acc;
        @(posedge fast_clk);
        @(negedge fast_clk);
        out_if.out_accept = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] word;
        logic         stop;
        logic         acc;
        logic         exp_valid;
        logic [W-1:0] exp_data;
        logic         exp_fe;
        logic         exp_ov;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic prev_valid;

        vecs[0] = '{16'hA5C3, 1'b1, 1'b0, 1'b1, 16'hA5C3, 1'b0, 1'b0};
        vecs[1] = '{16'h1234, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0};
        vecs[2] = '{16'hFFFF, 1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[3] = '{16'h1111, 1'b1, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b0};
        vecs[4] = '{16'h2222, 1'b1, 1'b0, 1'b1, 16'h1111, 1'b0, 1'b1};
        vecs[5] = '{16'h3333, 1'b1, 1'b1, 1'b1, 16'h3333, 1'b0, 1'b0};

        // Reset block
        reset = 1'b0;
        serial_in = 1'b1;
        out_if.out_accept = 1'b0;
        repeat (2) @(negedge fast_clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_valid", 32'(out_if.out_valid), 32'd0);
        check("rst_data", 32'(out_if.out_data), 32'd0);
        check("rst_fe", 32'(frame_err), 32'd0);
        check("rst_ov", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        reset = 1'b1;
        repeat (2) @(negedge fast_clk);

        // Back-to-back frame table
        prev_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].word, vecs[i].stop, vecs[i].acc);
            check($sformatf("vec%0d_ready_low", i), 32'(ready_low_cnt), 32'(W));
            check($sformatf("vec%0d_valid_pre", i), 32'(valid_before_stop), 32'(prev_valid));
            check($sformatf("vec%0d_valid", i), 32'(out_if.out_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_data", i), 32'(out_if.out_data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_fe", i), 32'(frame_err), 32'(vecs[i].exp_fe));
            check($sformatf("vec%0d_ov", i), 32'(overrun), 32'(vecs[i].exp_ov));
            prev_valid = vecs[i].exp_valid;
        end

        // Accept without capture drains the word, data holds
        serial_in = 1'b1;
        out_if.out_accept = 1'b1;
        @(posedge fast_clk);
        @(negedge fast_clk);
        out_if.out_accept = 1'b0;
        check("drain_valid", 32'(out_if.out_valid), 32'd0);
        check("drain_data", 32'(out_if.out_data), 32'h3333);
        check("ov_cleared", 32'(overrun), 32'd0);

        // Accept while nothing valid is ignored
        out_if.out_accept = 1'b1;
        @(posedge fast_clk);
        @(negedge fast_clk);
        out_if.out_accept = 1'b0;
        check("idle_acc_valid", 32'(out_if.out_valid), 32'd0);
        check("idle_acc_data", 32'(out_if.out_data), 32'h3333);
        check("idle_acc_state", 32'(state_dbg), 32'(IDLE));
        check("idle_acc_ready", 32'(ready), 32'd1);

        // Framing error, line held low five cycles
        send_frame(16'h00FF, 1'b0, 1'b0);
        check("ferr_pulse", 32'(frame_err), 32'd1);
        check("ferr_valid", 32'(out_if.out_valid), 32'd0);
        check("ferr_data", 32'(out_if.out_data), 32'h3333);
        check("ferr_ov", 32'(overrun), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge fast_clk);
            @(negedge fast_clk);
            check($sformatf("ferr_hold%0d_fe", i), 32'(frame_err), 32'd0);
            check($sformatf("ferr_hold%0d_state", i), 32'(state_dbg), 32'(WAIT_HIGH));
            check($sformatf("ferr_hold%0d_ready", i), 32'(ready), 32'd1);
        end
        serial_in = 1'b1;
        @(posedge fast_clk);
        @(negedge fast_clk);
        check("ferr_release_state", 32'(state_dbg), 32'(IDLE));
        check("ferr_release_busy", 32'(busy), 32'd0);

        // Reset mid-frame after data bit 7, then a clean frame
        serial_in = 1'b0;
        @(posedge fast_clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge fast_clk);
            serial_in = ((16'hDEAD >> i) & 16'h1) != 0;
            @(posedge fast_clk);
        end
        @(negedge fast_clk);
        check("mid_pre_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_ready", 32'(ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(out_if.out_valid), 32'd0);
        check("mid_rst_data", 32'(out_if.out_data), 32'd0);
        check("mid_rst_state", 32'(state_dbg), 32'(IDLE));
        repeat (2) @(posedge fast_clk);
        @(negedge fast_clk);
        reset = 1'b1;
        serial_in = 1'b1;
        @(posedge fast_clk);
        @(negedge fast_clk);
        send_frame(16'hBEEF, 1'b1, 1'b0);
        check("beef_ready_low", 32'(ready_low_cnt), 32'(W));
        check("beef_valid", 32'(out_if.out_valid), 32'd1);
        check("beef_data", 32'(out_if.out_data), 32'hBEEF);
        check("beef_fe", 32'(frame_err), 32'd0);
        check("beef_ov", 32'(overrun), 32'd0);
        serial_in = 1'b1;

        // Final report
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
